onewire_seq_ctrl: RTL and testbench
===================================

// Module: onewire_seq_ctrl
// PURPOSE
//  Transaction sequencer in front of master_top. Turns one start pulse into a full DS18B20-style
//  1-Wire sequence (read ROM, or convert + read scratchpad) by driving master_top cmd/data_in
//  one step at a time and waiting on its status handshake. Returns the 64-bit ROM ID or 16-bit temperature.
// PARAMETERS
//  STEP_TIMEOUT  200000  max clk cycles between a cmd issue and master DONE; expiry -> error
//  MAX_POLLS     1000    max READ_BYTE polls while waiting for conversion complete
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous, active-high reset
//  start      in   1   one-cycle request; accepted only when busy==0
//  mode       in   1   0 = READ_ROM sequence, 1 = CONVERT_READ sequence; sampled with start
//  busy       out  1   sequence in progress
//  done       out  1   one-cycle pulse at sequence end (success or error)
//  err_code   out  2   0 none, 1 no presence, 2 step timeout, 3 polls exhausted; valid with done
//  rom_id     out  64  last ROM ID read (mode 0)
//  temp       out  16  last scratchpad bytes {MSB,LSB} (mode 1)
//  m_cmd      out  3   to master_top cmd
//  m_data     out  8   to master_top data_in
//  m_rdata    in   64  from master_top data_out (byte reads in [7:0])
//  m_status   in   8   from master_top status
// BEHAVIOUR
//  Reset: busy=0, done=0, err_code=0, rom_id=0, temp=0, m_cmd=NOP, m_data=0, FSM IDLE, counters 0.
//  Master interface: m_cmd non-NOP for exactly one cycle (ISSUE), then NOP. Step completes on the
//   first cycle m_status[ST_DONE]=1 after issue. m_data held stable from ISSUE until step complete.
//  FSM: IDLE -start-> ISSUE -> WAIT -DONE-> EVAL -> (ISSUE next step | FINISH) ; FINISH -> IDLE.
//   WAIT: timer counts from 0; reaching STEP_TIMEOUT-1 without DONE -> FINISH, err=2.
//  Step program (step index 0..N, held in a case ROM keyed on {mode,step}):
//   mode 0: RESET; WRITE 0x33; READ_64 -> rom_id <= m_rdata.
//   mode 1: RESET; WRITE 0xCC; WRITE 0x44; READ_BYTE poll; RESET; WRITE 0xCC; WRITE 0xBE;
//           READ_BYTE -> temp[7:0]; READ_BYTE -> temp[15:8].
//  EVAL rules: after any RESET step, m_status[ST_PRESENCE]=0 -> FINISH, err=1.
//   Poll step: m_rdata[7:0]==0 -> poll_cnt+1, reissue same step; nonzero -> next step;
//   poll_cnt reaching MAX_POLLS -> FINISH, err=3. poll_cnt cleared at start.
//   m_status[ST_ERR]=1 on any step completion -> FINISH, err=2.
//  rom_id/temp update only on successful completion of their read step; keep old value on error.
//  done pulses in FINISH cycle; busy falls same cycle; new start accepted the cycle after.
//  start while busy: ignored, no queueing. Mid-sequence rst: outputs to reset values immediately,
//   m_cmd=NOP; master_top sharing rst also aborts.
//  DONE arriving in ISSUE cycle (before WAIT): ignored; only WAIT samples DONE.
// STRUCTURE
//  Shared package onewire_pkg: CMD_NOP=0, CMD_RESET=1, CMD_WRITE_BYTE=2, CMD_READ_BYTE=3,
//   CMD_READ_64=4; status bits ST_BUSY=0, ST_DONE=1, ST_PRESENCE=2, ST_ERR=3; ROM opcodes
//   0x33, 0xCC, 0x44, 0xBE; seq state enum; err_code constants.
//  One sub-module: onewire_step_rom (combinational {mode,step} -> {cmd, data, last, kind}).
//  FSM, timeout timer, poll counter and result registers stay in this module.
// TESTING
//  1 mode0, master model presence=1, data_out=64'h28FF_1234_5678_9A01 -> cmds RESET,WRITE 0x33,READ_64;
//    rom_id=64'h28FF12345678_9A01, err_code=0, single done pulse.
//  2 mode1, polls return 0,0,0xFF, scratch bytes 0x91,0x01 -> exactly 3 READ_BYTE polls, temp=16'h0191.
//  3 presence=0 on first RESET -> done with err_code=1 after 1 step; no WRITE issued; rom_id unchanged.
//  4 STEP_TIMEOUT=50, model never asserts DONE -> done at cycle 50 after issue, err_code=2, m_cmd=NOP.
//  5 MAX_POLLS=4, polls always 0 -> 4 polls then err_code=3; start during busy ignored throughout.
//  6 rst asserted mid-WAIT of step 3 -> busy=0, m_cmd=NOP same cycle; next start runs full clean sequence.

Source files
------------

// File: rtl/onewire_pkg.sv
// ----------------------------------------------------------------------------
// onewire_pkg
//   Constants shared by the 1-Wire sequencer and its step ROM: master_top
//   command codes, status bit positions, DS18B20 opcodes, error codes, step
//   kinds and the sequencer state encoding.
// ----------------------------------------------------------------------------
package onewire_pkg;

    // master_top command codes
    localparam logic [2:0] CMD_NOP        = 3'd0;
    localparam logic [2:0] CMD_RESET      = 3'd1;
    localparam logic [2:0] CMD_WRITE_BYTE = 3'd2;
    localparam logic [2:0] CMD_READ_BYTE  = 3'd3;
    localparam logic [2:0] CMD_READ_64    = 3'd4;

    // master_top status bit positions
    localparam int ST_BUSY     = 0;
    localparam int ST_DONE     = 1;
    localparam int ST_PRESENCE = 2;
    localparam int ST_ERR      = 3;

    // DS18B20 ROM / function opcodes
    localparam logic [7:0] OP_READ_ROM     = 8'h33;
    localparam logic [7:0] OP_SKIP_ROM     = 8'hCC;
    localparam logic [7:0] OP_CONVERT_T    = 8'h44;
    localparam logic [7:0] OP_READ_SCRATCH = 8'hBE;

    // err_code values
    localparam logic [1:0] ERR_NONE        = 2'd0;
    localparam logic [1:0] ERR_NO_PRESENCE = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT     = 2'd2;
    localparam logic [1:0] ERR_POLLS       = 2'd3;

    // What EVAL does with a step's read data
    localparam logic [2:0] K_PLAIN   = 3'd0;  // nothing captured
    localparam logic [2:0] K_POLL    = 3'd1;  // zero byte -> repeat step
    localparam logic [2:0] K_ROM_ID  = 3'd2;  // 64-bit ROM ID
    localparam logic [2:0] K_TEMP_LO = 3'd3;  // scratchpad LSB
    localparam logic [2:0] K_TEMP_HI = 3'd4;  // scratchpad MSB, commits temp

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_EVAL   = 3'd3,
        S_FINISH = 3'd4
    } seq_state_e;

endpackage

// File: rtl/onewire_step_rom.sv
// ----------------------------------------------------------------------------
// onewire_step_rom
//   Combinational step program for the sequencer, keyed on {mode, step}.
//   Ports:
//     mode_i  in  1  0 = READ_ROM program, 1 = CONVERT_READ program
//     step_i  in  4  step index
//     cmd_o   out 3  master_top command for this step
//     data_o  out 8  byte presented on master data_in (opcode for writes)
//     last_o  out 1  final step of the program
//     kind_o  out 3  how the step's read data is used (K_*)
// ----------------------------------------------------------------------------
module onewire_step_rom
    import onewire_pkg::*;
(
    input  logic       mode_i,
    input  logic [3:0] step_i,
    output logic [2:0] cmd_o,
    output logic [7:0] data_o,
    output logic       last_o,
    output logic [2:0] kind_o
);

    always_comb begin
        cmd_o  = CMD_NOP;
        data_o = 8'h00;
        last_o = 1'b1;
        kind_o = K_PLAIN;
        case ({mode_i, step_i})
            // READ_ROM: RESET, 0x33, READ_64
            {1'b0, 4'd0}: begin cmd_o = CMD_RESET;      last_o = 1'b0; end
            {1'b0, 4'd1}: begin cmd_o = CMD_WRITE_BYTE; data_o = OP_READ_ROM; last_o = 1'b0; end
            {1'b0, 4'd2}: begin cmd_o = CMD_READ_64;    kind_o = K_ROM_ID; end
            // CONVERT_READ: RESET, 0xCC, 0x44, poll, RESET, 0xCC, 0xBE, LSB, MSB
            {1'b1, 4'd0}: begin cmd_o = CMD_RESET;      last_o = 1'b0; end
            {1'b1, 4'd1}: begin cmd_o = CMD_WRITE_BYTE; data_o = OP_SKIP_ROM;  last_o = 1'b0; end
            {1'b1, 4'd2}: begin cmd_o = CMD_WRITE_BYTE; data_o = OP_CONVERT_T; last_o = 1'b0; end
            {1'b1, 4'd3}: begin cmd_o = CMD_READ_BYTE;  kind_o = K_POLL; last_o = 1'b0; end
            {1'b1, 4'd4}: begin cmd_o = CMD_RESET;      last_o = 1'b0; end
            {1'b1, 4'd5}: begin cmd_o = CMD_WRITE_BYTE; data_o = OP_SKIP_ROM;     last_o = 1'b0; end
            {1'b1, 4'd6}: begin cmd_o = CMD_WRITE_BYTE; data_o = OP_READ_SCRATCH; last_o = 1'b0; end
            {1'b1, 4'd7}: begin cmd_o = CMD_READ_BYTE;  kind_o = K_TEMP_LO; last_o = 1'b0; end
            {1'b1, 4'd8}: begin cmd_o = CMD_READ_BYTE;  kind_o = K_TEMP_HI; end
            default: ;
        endcase
    end

endmodule

// File: rtl/onewire_seq_ctrl.sv
// ----------------------------------------------------------------------------
// onewire_seq_ctrl
//   Sequencer in front of master_top: one start pulse runs a whole DS18B20
//   transaction (read ROM, or convert + read scratchpad), one master step at
//   a time, and returns the ROM ID or the 16-bit temperature.
//   Ports:
//     clk, rst      clock, asynchronous active-high reset
//     start, mode   request (taken only when idle), program select
//     busy, done    sequence running, one-cycle end pulse
//     err_code      0 ok, 1 no presence, 2 step timeout/master error,
//                   3 conversion polls exhausted (valid with done)
//     rom_id, temp  last successful results
//     m_cmd, m_data command / data_in to master_top
//     m_rdata       master data_out (byte reads in [7:0])
//     m_status      master status (ST_* bits)
// ----------------------------------------------------------------------------
module onewire_seq_ctrl
    import onewire_pkg::*;
#(
    parameter int STEP_TIMEOUT = 200000,
    parameter int MAX_POLLS    = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err_code,
    output logic [63:0] rom_id,
    output logic [15:0] temp,
    output logic [2:0]  m_cmd,
    output logic [7:0]  m_data,
    input  logic [63:0] m_rdata,
    input  logic [7:0]  m_status
);

    localparam int TMR_W  = (STEP_TIMEOUT > 2) ? $clog2(STEP_TIMEOUT) : 1;
    localparam int POLL_W = (MAX_POLLS > 1) ? $clog2(MAX_POLLS + 1) : 1;

    seq_state_e          state_q;
    logic                mode_q;
    logic [3:0]          step_q;
    logic [TMR_W-1:0]    timer_q;
    logic [POLL_W-1:0]   poll_cnt_q;
    // Attributes of the step in flight, latched when it is issued
    logic [2:0]          cur_cmd_q;
    logic [2:0]          cur_kind_q;
    logic                cur_last_q;
    // Master response captured on DONE, evaluated one cycle later
    logic [63:0]         rd_q;
    logic                pres_q;
    logic                serr_q;
    logic [7:0]          temp_lo_q;
    logic                busy_q;
    logic                done_q;
    logic [1:0]          err_q;
    logic [63:0]         rom_id_q;
    logic [15:0]         temp_q;
    logic [2:0]          m_cmd_q;
    logic [7:0]          m_data_q;

    // The ROM is addressed with the step about to be issued so the command
    // can be registered onto m_cmd on the same edge that enters ISSUE.
    logic                rom_mode_d;
    logic [3:0]          rom_step_d;
    logic [2:0]          rom_cmd;
    logic [7:0]          rom_data;
    logic                rom_last;
    logic [2:0]          rom_kind;

    assign rom_mode_d = (state_q == S_IDLE) ? mode : mode_q;
    assign rom_step_d = (state_q == S_IDLE) ? 4'd0 : step_q + 4'd1;

    onewire_step_rom u_rom (
        .mode_i (rom_mode_d),
        .step_i (rom_step_d),
        .cmd_o  (rom_cmd),
        .data_o (rom_data),
        .last_o (rom_last),
        .kind_o (rom_kind)
    );

    logic [4:0] unused_status;
    assign unused_status = {m_status[7:4], m_status[ST_BUSY]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mode_q     <= 1'b0;
            step_q     <= '0;
            timer_q    <= '0;
            poll_cnt_q <= '0;
            cur_cmd_q  <= CMD_NOP;
            cur_kind_q <= K_PLAIN;
            cur_last_q <= 1'b0;
            rd_q       <= '0;
            pres_q     <= 1'b0;
            serr_q     <= 1'b0;
            temp_lo_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= ERR_NONE;
            rom_id_q   <= '0;
            temp_q     <= '0;
            m_cmd_q    <= CMD_NOP;
            m_data_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        mode_q     <= mode;
                        step_q     <= '0;
                        poll_cnt_q <= '0;
                        busy_q     <= 1'b1;
                        m_cmd_q    <= rom_cmd;
                        m_data_q   <= rom_data;
                        cur_cmd_q  <= rom_cmd;
                        cur_kind_q <= rom_kind;
                        cur_last_q <= rom_last;
                        state_q    <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    // DONE is deliberately not looked at here
                    m_cmd_q <= CMD_NOP;
                    timer_q <= '0;
                    state_q <= S_WAIT;
                end

                S_WAIT: begin
                    if (m_status[ST_DONE]) begin
                        rd_q    <= m_rdata;
                        pres_q  <= m_status[ST_PRESENCE];
                        serr_q  <= m_status[ST_ERR];
                        state_q <= S_EVAL;
                    end else if (timer_q == TMR_W'(STEP_TIMEOUT - 1)) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        err_q   <= ERR_TIMEOUT;
                        state_q <= S_FINISH;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end

                S_EVAL: begin
                    if (serr_q) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        err_q   <= ERR_TIMEOUT;
                        state_q <= S_FINISH;
                    end else if (cur_cmd_q == CMD_RESET && !pres_q) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        err_q   <= ERR_NO_PRESENCE;
                        state_q <= S_FINISH;
                    end else if (cur_kind_q == K_POLL && rd_q[7:0] == 8'h00) begin
                        // Conversion still running: re-read the same step,
                        // m_data is left untouched.
                        if (poll_cnt_q == POLL_W'(MAX_POLLS - 1)) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            err_q   <= ERR_POLLS;
                            state_q <= S_FINISH;
                        end else begin
                            poll_cnt_q <= poll_cnt_q + POLL_W'(1);
                            m_cmd_q    <= cur_cmd_q;
                            state_q    <= S_ISSUE;
                        end
                    end else begin
                        if (cur_kind_q == K_ROM_ID)  rom_id_q  <= rd_q;
                        // LSB is staged so temp only changes once both bytes are in
                        if (cur_kind_q == K_TEMP_LO) temp_lo_q <= rd_q[7:0];
                        if (cur_kind_q == K_TEMP_HI) temp_q    <= {rd_q[7:0], temp_lo_q};
                        if (cur_last_q) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            err_q   <= ERR_NONE;
                            state_q <= S_FINISH;
                        end else begin
                            step_q     <= rom_step_d;
                            m_cmd_q    <= rom_cmd;
                            m_data_q   <= rom_data;
                            cur_cmd_q  <= rom_cmd;
                            cur_kind_q <= rom_kind;
                            cur_last_q <= rom_last;
                            state_q    <= S_ISSUE;
                        end
                    end
                end

                S_FINISH: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err_code = err_q;
    assign rom_id   = rom_id_q;
    assign temp     = temp_q;
    assign m_cmd    = m_cmd_q;
    assign m_data   = m_data_q;

endmodule

// File: tb/tb_onewire_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_onewire_seq_ctrl
//   Bench for onewire_seq_ctrl with a behavioural master_top model. Small
//   STEP_TIMEOUT / MAX_POLLS keep timeout and poll-exhaustion cases short.
// ----------------------------------------------------------------------------
module tb_onewire_seq_ctrl;
    import onewire_pkg::*;

    localparam int TO = 50;
    localparam int MP = 4;

    logic        clk = 1'b0;
    logic        rst, start, mode;
    logic        busy, done;
    logic [1:0]  err_code;
    logic [63:0] rom_id;
    logic [15:0] temp;
    logic [2:0]  m_cmd;
    logic [7:0]  m_data;
    logic [63:0] m_rdata;
    logic [7:0]  m_status;

    onewire_seq_ctrl #(.STEP_TIMEOUT(TO), .MAX_POLLS(MP)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .busy(busy), .done(done), .err_code(err_code),
        .rom_id(rom_id), .temp(temp),
        .m_cmd(m_cmd), .m_data(m_data),
        .m_rdata(m_rdata), .m_status(m_status)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- master_top model ----------------
    bit          cfg_pres = 1'b1;
    bit          cfg_serr = 1'b0;
    bit          cfg_hang = 1'b0;
    int          cfg_lat  = 2;
    logic [63:0] cfg_rom  = '0;
    logic [7:0]  rbytes[$];
    logic [2:0]  log_cmd[$];
    logic [7:0]  log_data[$];
    logic        pend, st_done, st_pres, st_err;
    int          cnt;
    logic [2:0]  pcmd;
    logic [7:0]  pdata;
    logic [63:0] rdata;
    int          stab_bad = 0;

    assign m_status = {4'b0, st_err, st_pres, st_done, pend};
    assign m_rdata  = rdata;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= 1'b0; cnt <= 0; st_done <= 1'b0; st_pres <= 1'b0;
            st_err <= 1'b0; rdata <= '0; pcmd <= CMD_NOP; pdata <= '0;
        end else begin
            st_done <= 1'b0;
            if (m_cmd != CMD_NOP) begin
                log_cmd.push_back(m_cmd);
                log_data.push_back(m_data);
                pend  <= !cfg_hang;
                cnt   <= cfg_lat;
                pcmd  <= m_cmd;
                pdata <= m_data;
            end else if (pend) begin
                if (cnt == 0) begin
                    pend    <= 1'b0;
                    st_done <= 1'b1;
                    st_err  <= cfg_serr;
                    if (m_data !== pdata) stab_bad <= stab_bad + 1;
                    case (pcmd)
                        CMD_RESET:     begin st_pres <= cfg_pres; rdata <= '0; end
                        CMD_READ_BYTE: begin
                            if (rbytes.size() > 0) rdata <= {56'h0, rbytes.pop_front()};
                            else                   rdata <= 64'hFF;
                        end
                        CMD_READ_64:   rdata <= cfg_rom;
                        default:       rdata <= {$urandom, $urandom};
                    endcase
                end else begin
                    cnt <= cnt - 1;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    logic [2:0]  exp_cmd[$];
    logic [7:0]  exp_data[$];
    logic [63:0] exp_rom  = '0;
    logic [15:0] exp_temp = '0;

    task automatic add(input logic [2:0] c, input logic [7:0] d);
        exp_cmd.push_back(c);
        exp_data.push_back(d);
    endtask

    // Expected command trace, error and results from the transaction rules
    task automatic ref_model(input logic md, input bit pres, input bit serr, input int nz,
                             input logic [7:0] lo, input logic [7:0] hi,
                             input logic [63:0] rv, output logic [1:0] err);
        exp_cmd.delete(); exp_data.delete();
        err = ERR_NONE;
        add(CMD_RESET, 8'h00);
        if (serr)       err = ERR_TIMEOUT;
        else if (!pres) err = ERR_NO_PRESENCE;
        else if (!md) begin
            add(CMD_WRITE_BYTE, 8'h33);
            add(CMD_READ_64, 8'h00);
            exp_rom = rv;
        end else begin
            add(CMD_WRITE_BYTE, 8'hCC);
            add(CMD_WRITE_BYTE, 8'h44);
            for (int i = 0; i < nz && err == ERR_NONE; i++) begin
                add(CMD_READ_BYTE, 8'h00);
                if (i + 1 == MP) err = ERR_POLLS;
            end
            if (err == ERR_NONE) begin
                add(CMD_READ_BYTE, 8'h00);  // the nonzero poll reply
                add(CMD_RESET, 8'h00);
                add(CMD_WRITE_BYTE, 8'hCC);
                add(CMD_WRITE_BYTE, 8'hBE);
                add(CMD_READ_BYTE, 8'h00);
                add(CMD_READ_BYTE, 8'h00);
                exp_temp = {hi, lo};
            end
        end
    endtask

    task automatic setup(input bit pres, input bit serr, input int nz, input logic [7:0] pb,
                         input logic [7:0] lo, input logic [7:0] hi,
                         input logic [63:0] rv, input int lat);
        cfg_pres = pres; cfg_serr = serr; cfg_rom = rv; cfg_lat = lat;
        rbytes.delete();
        repeat (nz) rbytes.push_back(8'h00);
        rbytes.push_back(pb);
        rbytes.push_back(lo);
        rbytes.push_back(hi);
    endtask

    task automatic chk_trace(input string tag);
        int bad = 0;
        chk({tag, "_ncmd"}, log_cmd.size(), exp_cmd.size());
        if (log_cmd.size() == exp_cmd.size()) begin
            foreach (exp_cmd[i])
                if (log_cmd[i] !== exp_cmd[i] ||
                    (exp_cmd[i] == CMD_WRITE_BYTE && log_data[i] !== exp_data[i])) bad++;
        end
        chk({tag, "_trace_bad"}, bad, 0);
    endtask

    // Run one sequence; optionally spam start/mode while busy
    task automatic run_seq(input string tag, input logic md, input bit spam, output int ndone);
        int cyc;
        log_cmd.delete(); log_data.delete();
        @(negedge clk); mode = md; start = 1'b1;
        @(negedge clk); start = 1'b0; mode = ~md;
        ndone = 0; cyc = 0;
        while (ndone == 0 && cyc < 2000) begin
            if (spam) begin
                start = 1'($urandom_range(0, 1));
                mode  = 1'($urandom_range(0, 1));
            end
            @(negedge clk); cyc++;
            if (done) ndone++;
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, 64'(ndone > 0), 1);
        repeat (4) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk({tag, "_idle_after"}, busy, 1'b0);
    endtask

    typedef struct {
        logic        md;
        bit          pres;
        bit          serr;
        int          nz;
        logic [7:0]  pb, lo, hi;
        logic [63:0] rv;
        bit          spam;
        logic [1:0]  e_err;
        int          e_ncmd;
        logic [63:0] e_rom;
        logic [15:0] e_temp;
    } vec_t;

    vec_t vt[7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         nd, n;
        logic [1:0] e_err;
        string      tg;

        vt[0] = '{1'b0, 1'b1, 1'b0, 0, 8'hFF, 8'h00, 8'h00, 64'h28FF_1234_5678_9A01, 1'b0,
                  ERR_NONE, 3, 64'h28FF_1234_5678_9A01, 16'h0000};
        vt[1] = '{1'b1, 1'b1, 1'b0, 2, 8'hFF, 8'h91, 8'h01, 64'h0, 1'b0,
                  ERR_NONE, 11, 64'h28FF_1234_5678_9A01, 16'h0191};
        vt[2] = '{1'b0, 1'b0, 1'b0, 0, 8'hFF, 8'h00, 8'h00, 64'hDEAD_BEEF_0000_0001, 1'b0,
                  ERR_NO_PRESENCE, 1, 64'h28FF_1234_5678_9A01, 16'h0191};
        vt[3] = '{1'b1, 1'b1, 1'b0, 4, 8'hFF, 8'h11, 8'h22, 64'h0, 1'b1,
                  ERR_POLLS, 7, 64'h28FF_1234_5678_9A01, 16'h0191};
        vt[4] = '{1'b1, 1'b0, 1'b0, 0, 8'hFF, 8'h33, 8'h44, 64'h0, 1'b0,
                  ERR_NO_PRESENCE, 1, 64'h28FF_1234_5678_9A01, 16'h0191};
        vt[5] = '{1'b0, 1'b1, 1'b1, 0, 8'hFF, 8'h00, 8'h00, 64'h0123_0000_0000_0000, 1'b0,
                  ERR_TIMEOUT, 1, 64'h28FF_1234_5678_9A01, 16'h0191};
        vt[6] = '{1'b0, 1'b1, 1'b0, 0, 8'hFF, 8'h00, 8'h00, 64'h0123_4567_89AB_CDEF, 1'b1,
                  ERR_NONE, 3, 64'h0123_4567_89AB_CDEF, 16'h0191};

        rst = 1'b1; start = 1'b0; mode = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err_code, ERR_NONE);
        chk("rst_rom", rom_id, 64'h0);
        chk("rst_temp", temp, 16'h0);
        chk("rst_mcmd", m_cmd, CMD_NOP);
        chk("rst_mdata", m_data, 8'h00);
        rst = 1'b0;

        // ---- table of directed sequences ----
        foreach (vt[i]) begin
            tg = $sformatf("v%0d", i);
            setup(vt[i].pres, vt[i].serr, vt[i].nz, vt[i].pb, vt[i].lo, vt[i].hi, vt[i].rv,
                  1 + (i % 3));
            ref_model(vt[i].md, vt[i].pres, vt[i].serr, vt[i].nz, vt[i].lo, vt[i].hi,
                      vt[i].rv, e_err);
            run_seq(tg, vt[i].md, vt[i].spam, nd);
            chk({tg, "_err"}, err_code, vt[i].e_err);
            chk({tg, "_ncmd_tab"}, log_cmd.size(), vt[i].e_ncmd);
            chk({tg, "_rom"}, rom_id, vt[i].e_rom);
            chk({tg, "_temp"}, temp, vt[i].e_temp);
            chk({tg, "_ndone"}, nd, 1);
            chk_trace(tg);
        end
        cfg_serr = 1'b0;

        // ---- step timeout: master never answers ----
        cfg_hang = 1'b1;
        log_cmd.delete(); log_data.delete();
        @(negedge clk); mode = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("to_issue_cmd", m_cmd, CMD_RESET);
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        // STEP_TIMEOUT wait cycles after the issue cycle, then the done cycle
        chk("to_latency", n, TO + 1);
        chk("to_err", err_code, ERR_TIMEOUT);
        chk("to_mcmd", m_cmd, CMD_NOP);
        chk("to_busy", busy, 1'b0);
        chk("to_rom_kept", rom_id, 64'h0123_4567_89AB_CDEF);
        chk("to_temp_kept", temp, 16'h0191);
        cfg_hang = 1'b0;
        repeat (3) @(negedge clk);

        // ---- reset while waiting on step 3 ----
        setup(1'b1, 1'b0, 1, 8'h5A, 8'h10, 8'h20, 64'h0, 10);
        log_cmd.delete(); log_data.delete();
        @(negedge clk); mode = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (log_cmd.size() < 4 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("mr_reached_step3", 64'(log_cmd.size() >= 4), 1);
        repeat (3) @(negedge clk);
        chk("mr_busy_before", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("mr_busy", busy, 1'b0);
        chk("mr_mcmd", m_cmd, CMD_NOP);
        chk("mr_rom", rom_id, 64'h0);
        chk("mr_temp", temp, 16'h0);
        @(negedge clk); rst = 1'b0;
        exp_rom = '0; exp_temp = '0;
        setup(1'b1, 1'b0, 0, 8'hFF, 8'h00, 8'h00, 64'hA5A5_0000_1111_2222, 2);
        ref_model(1'b0, 1'b1, 1'b0, 0, 8'h00, 8'h00, 64'hA5A5_0000_1111_2222, e_err);
        run_seq("mr_clean", 1'b0, 1'b0, nd);
        chk("mr_clean_err", err_code, e_err);
        chk("mr_clean_rom", rom_id, exp_rom);
        chk("mr_clean_ndone", nd, 1);
        chk_trace("mr_clean");

        // ---- randomized sequences against the reference model ----
        for (int k = 0; k < 24; k++) begin
            logic        md;
            bit          pres, serr, spam;
            int          nz, lat;
            logic [7:0]  pb, lo, hi;
            logic [63:0] rv;
            md   = 1'($urandom_range(0, 1));
            pres = ($urandom_range(0, 7) != 0);
            serr = pres && ($urandom_range(0, 9) == 0);
            nz   = $urandom_range(0, 5);
            pb   = 8'($urandom_range(1, 255));
            lo   = 8'($urandom);
            hi   = 8'($urandom);
            rv   = {$urandom, $urandom};
            lat  = $urandom_range(0, 6);
            spam = 1'($urandom_range(0, 1));
            tg   = $sformatf("r%0d", k);
            setup(pres, serr, nz, pb, lo, hi, rv, lat);
            ref_model(md, pres, serr, nz, lo, hi, rv, e_err);
            run_seq(tg, md, spam, nd);
            chk({tg, "_err"}, err_code, e_err);
            chk({tg, "_rom"}, rom_id, exp_rom);
            chk({tg, "_temp"}, temp, exp_temp);
            chk({tg, "_ndone"}, nd, 1);
            chk_trace(tg);
        end
        cfg_serr = 1'b0;

        chk("data_stable", stab_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
